// File: rtl/tick_div_pkg.sv
//------------------------------------------------------------------------------
// Module  : tick_div_pkg
// Brief   : Shared clock-rate and divisor constants for the tick divider bank.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tick_div_pkg;

    localparam int CLK_HZ   = 50_000_000;
    localparam int DIV_1HZ  = 50_000_000;
    localparam int DIV_4HZ  = 12_500_000;
    localparam int DIV_1KHZ = 50_000;
    localparam int MIN_DIV  = 2;

endpackage : tick_div_pkg

`default_nettype wire

// File: rtl/tick_div_channel.sv
//------------------------------------------------------------------------------
// Module  : tick_div_channel
// Brief   : One divider channel: counter, active/shadow divisor, tick and square.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_div_channel
    import tick_div_pkg::*;
#(
    parameter int               CNT_W    = 28,
    parameter logic [CNT_W-1:0] INIT_DIV = CNT_W'(DIV_1HZ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_restart,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_data,
    output logic             o_tick,
    output logic             o_square,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_square;

    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_wrap    = i_en && (r_cnt == (r_active - C_ONE));
    assign w_cnt_inc = r_cnt + C_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_active  <= INIT_DIV;
            r_shadow  <= INIT_DIV;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_square  <= 1'b0;
        end else if (i_restart) begin
            r_cnt     <= '0;
            r_square  <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
            if (r_pending) begin
                r_active <= r_shadow;
            end
        end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
                // Next count is 0, which is always below D>>1 since D >= 2.
                r_cnt    <= '0;
                r_square <= 1'b0;
                if (i_wr) begin
                    r_active  <= i_wr_data;
                    r_shadow  <= i_wr_data;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_active  <= r_shadow;
                    r_pending <= 1'b0;
                end
            end else begin
                if (i_en) begin
                    r_cnt    <= w_cnt_inc;
                    r_square <= (w_cnt_inc >= (r_active >> 1));
                end
                if (i_wr) begin
                    r_shadow  <= i_wr_data;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_square  = r_square;
    assign o_pending = r_pending;

endmodule : tick_div_channel

`default_nettype wire

// File: rtl/tick_divider_bank.sv
//------------------------------------------------------------------------------
// Module  : tick_divider_bank
// Brief   : Bank of independent programmable clock-enable dividers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_divider_bank
    import tick_div_pkg::*;
#(
    parameter int                          NUM_CH   = 3,
    parameter int                          CNT_W    = 28,
    parameter logic [NUM_CH*CNT_W-1:0]     DIV_INIT = {NUM_CH{CNT_W'(DIV_1HZ)}}
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [NUM_CH-1:0]                                 en_i,
    input  logic [NUM_CH-1:0]                                 restart_i,
    input  logic                                              div_wr_i,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]    div_sel_i,
    input  logic [CNT_W-1:0]                                  div_data_i,
    output logic [NUM_CH-1:0]                                 tick_o,
    output logic [NUM_CH-1:0]                                 square_o,
    output logic [NUM_CH-1:0]                                 pending_o
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Divisors below MIN_DIV would give a zero-length or single-cycle period.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : d;
    endfunction

    logic [CNT_W-1:0] w_wr_data;

    assign w_wr_data = clamp_div(div_data_i);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_wr;

        // Selects at or beyond NUM_CH match no channel and are dropped.
        assign w_wr = div_wr_i && (div_sel_i == SEL_W'(g));

        tick_div_channel #(
            .CNT_W    (CNT_W),
            .INIT_DIV (clamp_div(DIV_INIT[g*CNT_W +: CNT_W]))
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .i_en      (en_i[g]),
            .i_restart (restart_i[g]),
            .i_wr      (w_wr),
            .i_wr_data (w_wr_data),
            .o_tick    (tick_o[g]),
            .o_square  (square_o[g]),
            .o_pending (pending_o[g])
        );
    end

endmodule : tick_divider_bank

`default_nettype wire

// File: tb/tb_tick_divider_bank.sv
//------------------------------------------------------------------------------
// Module  : tb_tick_divider_bank
// Brief   : Scoreboard bench for tick_divider_bank with DIV_INIT = {2,4,5}.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_divider_bank;

    localparam int NCH    = 3;
    localparam int W      = 28;
    localparam int K_TICK = 0;
    localparam int K_SQ   = 1;
    localparam int K_PEND = 2;

    typedef struct { int at; int ch; int kind; logic val; } samp_t;
    typedef struct { int at; int ch; } tick_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [NCH-1:0] en_i;
    logic [NCH-1:0] restart_i;
    logic           div_wr_i;
    logic [1:0]     div_sel_i;
    logic [W-1:0]   div_data_i;
    logic [NCH-1:0] tick_o;
    logic [NCH-1:0] square_o;
    logic [NCH-1:0] pending_o;

    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    bit    done   = 1'b0;
    int    base;
    samp_t sq_q[$];
    tick_t tk_q[$];
    logic [7:0] sq_tab [NCH];

    tick_divider_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (W),
        .DIV_INIT ({28'd2, 28'd4, 28'd5})
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en_i       (en_i),
        .restart_i  (restart_i),
        .div_wr_i   (div_wr_i),
        .div_sel_i  (div_sel_i),
        .div_data_i (div_data_i),
        .tick_o     (tick_o),
        .square_o   (square_o),
        .pending_o  (pending_o)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic exp_val(input int at, input int ch, input int kind, input logic val);
        samp_t s;
        s.at = at; s.ch = ch; s.kind = kind; s.val = val;
        sq_q.push_back(s);
    endtask

    task automatic exp_tick(input int at, input int ch);
        tick_t t;
        t.at = at; t.ch = ch;
        tk_q.push_back(t);
    endtask

    task automatic wr(input logic en, input int sel, input int data);
        div_wr_i   = en;
        div_sel_i  = 2'(sel);
        div_data_i = W'(data);
    endtask

    // Free running from cnt=0 with the reset divisors 5/4/2.
    task automatic run_free(input int r);
        for (int k = 1; k <= 20; k++) begin
            if (k % 5 == 0) exp_tick(r + k, 0);
            if (k % 4 == 0) exp_tick(r + k, 1);
            if (k % 2 == 0) exp_tick(r + k, 2);
        end
        for (int ch = 0; ch < NCH; ch++)
            for (int k = 1; k <= 8; k++)
                exp_val(r + k, ch, K_SQ, sq_tab[ch][k-1]);
    endtask

    // Monitor: every tick pops the channel's next expected tick cycle.
    always @(negedge clock) begin
        int   idx;
        logic act;
        if (done) begin
            foreach (tk_q[i]) begin
                checks++; errors++;
                $display("FAIL tick_ch%0d: no tick seen, required at cycle %0d", tk_q[i].ch, tk_q[i].at);
            end
            foreach (sq_q[i]) begin
                checks++; errors++;
                $display("FAIL sample_ch%0d_k%0d: never sampled, required %0b at cycle %0d",
                         sq_q[i].ch, sq_q[i].kind, sq_q[i].val, sq_q[i].at);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (tick_o[ch] === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < tk_q.size(); i++)
                        if (idx < 0 && tk_q[i].ch == ch) idx = i;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL tick_ch%0d: unexpected tick at cycle %0d", ch, cyc);
                    end else begin
                        if (tk_q[idx].at != cyc) begin
                            errors++;
                            $display("FAIL tick_ch%0d: tick at cycle %0d, required at cycle %0d",
                                     ch, cyc, tk_q[idx].at);
                        end
                        tk_q.delete(idx);
                    end
                end
            end
            for (int i = sq_q.size() - 1; i >= 0; i--) begin
                if (sq_q[i].at == cyc) begin
                    case (sq_q[i].kind)
                        K_TICK:  act = tick_o[sq_q[i].ch];
                        K_SQ:    act = square_o[sq_q[i].ch];
                        default: act = pending_o[sq_q[i].ch];
                    endcase
                    checks++;
                    if (act !== sq_q[i].val) begin
                        errors++;
                        $display("FAIL %s_ch%0d: cycle %0d got %0b, required %0b",
                                 (sq_q[i].kind == K_TICK) ? "tick" :
                                 (sq_q[i].kind == K_SQ) ? "square" : "pending",
                                 sq_q[i].ch, cyc, act, sq_q[i].val);
                    end
                    sq_q.delete(i);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; en_i = '0; restart_i = '0;
        wr(1'b0, 0, 0);
        sq_tab[0] = 8'b11001110;
        sq_tab[1] = 8'b01100110;
        sq_tab[2] = 8'b01010101;

        // Reset state
        nxt();
        base = cyc;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_val(base + 2, ch, K_TICK, 1'b0);
            exp_val(base + 2, ch, K_SQ, 1'b0);
            exp_val(base + 2, ch, K_PEND, 1'b0);
        end
        nxt(); nxt();

        // Free run with reset divisors
        base = cyc; reset = 1'b0; en_i = 3'b111;
        run_free(base);
        repeat (20) nxt();

        // ch0: write 0 then 1, both clamp to 2; takes effect at next wrap
        base = cyc; en_i = '0; wr(1'b1, 0, 0);
        exp_val(base + 1, 0, K_PEND, 1'b1);
        exp_val(base + 2, 0, K_PEND, 1'b1);
        exp_val(base + 6, 0, K_PEND, 1'b1);
        exp_val(base + 7, 0, K_PEND, 1'b0);
        exp_val(base + 8, 0, K_SQ, 1'b1);
        exp_val(base + 9, 0, K_SQ, 1'b0);
        exp_tick(base + 7, 0); exp_tick(base + 9, 0);
        exp_tick(base + 11, 0); exp_tick(base + 13, 0);
        nxt(); wr(1'b1, 0, 1);
        nxt(); wr(1'b0, 0, 0); en_i = 3'b001;
        repeat (11) nxt();

        // ch1: out-of-range write, mid-period write of 8, then write 4 on a wrap edge
        base = cyc; en_i = 3'b010; wr(1'b1, 3, 2);
        for (int ch = 0; ch < NCH; ch++) exp_val(base + 1, ch, K_PEND, 1'b0);
        exp_val(base + 3, 1, K_PEND, 1'b1);
        exp_val(base + 4, 1, K_PEND, 1'b0);
        exp_val(base + 28, 1, K_PEND, 1'b0);
        exp_val(base + 7, 1, K_SQ, 1'b0);
        exp_val(base + 8, 1, K_SQ, 1'b1);
        exp_tick(base + 4, 1); exp_tick(base + 12, 1); exp_tick(base + 20, 1);
        exp_tick(base + 28, 1); exp_tick(base + 32, 1); exp_tick(base + 36, 1);
        nxt(); wr(1'b0, 0, 0);
        nxt(); wr(1'b1, 1, 8);
        nxt(); wr(1'b0, 0, 0);
        repeat (24) nxt(); wr(1'b1, 1, 4);
        nxt(); wr(1'b0, 0, 0);
        repeat (8) nxt();

        // ch1: freeze 10 cycles at cnt=2 with a write of 6 pending meanwhile
        base = cyc;
        exp_tick(base + 14, 1); exp_tick(base + 20, 1); exp_tick(base + 26, 1);
        exp_val(base + 2, 1, K_SQ, 1'b1);
        exp_val(base + 5, 1, K_SQ, 1'b1);
        exp_val(base + 12, 1, K_SQ, 1'b1);
        exp_val(base + 13, 1, K_SQ, 1'b1);
        exp_val(base + 14, 1, K_SQ, 1'b0);
        exp_val(base + 16, 1, K_SQ, 1'b0);
        exp_val(base + 17, 1, K_SQ, 1'b1);
        exp_val(base + 5, 1, K_PEND, 1'b1);
        exp_val(base + 12, 1, K_PEND, 1'b1);
        exp_val(base + 14, 1, K_PEND, 1'b0);
        nxt(); nxt(); en_i = '0;
        nxt(); nxt(); wr(1'b1, 1, 6);
        nxt(); wr(1'b0, 0, 0);
        repeat (7) nxt(); en_i = 3'b010;
        repeat (14) nxt(); en_i = '0;

        // ch0: restart with a pending divisor of 3, then reset mid-period
        base = cyc; wr(1'b1, 0, 3);
        exp_val(base + 1, 0, K_PEND, 1'b1);
        exp_val(base + 2, 0, K_PEND, 1'b1);
        exp_val(base + 3, 0, K_PEND, 1'b0);
        exp_val(base + 2, 0, K_SQ, 1'b1);
        exp_val(base + 3, 0, K_SQ, 1'b0);
        exp_val(base + 3, 0, K_TICK, 1'b0);
        exp_val(base + 5, 0, K_SQ, 1'b1);
        exp_val(base + 13, 0, K_SQ, 1'b1);
        exp_val(base + 13, 1, K_PEND, 1'b1);
        exp_val(base + 13, 2, K_PEND, 1'b1);
        exp_tick(base + 6, 0); exp_tick(base + 9, 0); exp_tick(base + 12, 0);
        for (int ch = 0; ch < NCH; ch++) begin
            exp_val(base + 14, ch, K_TICK, 1'b0);
            exp_val(base + 14, ch, K_SQ, 1'b0);
            exp_val(base + 14, ch, K_PEND, 1'b0);
        end
        nxt(); wr(1'b0, 0, 0); en_i = 3'b001;
        nxt(); restart_i = 3'b001;
        nxt(); restart_i = '0;
        repeat (8) nxt(); wr(1'b1, 2, 7);
        nxt(); wr(1'b1, 1, 9);
        nxt(); reset = 1'b1; restart_i = 3'b111; wr(1'b1, 0, 9);
        nxt(); reset = 1'b0; restart_i = '0; wr(1'b0, 0, 0); en_i = 3'b111;

        // Reset divisors restored; the writes issued with reset were dropped
        base = cyc;
        for (int ch = 0; ch < NCH; ch++) exp_val(base + 1, ch, K_PEND, 1'b0);
        run_free(base);
        repeat (20) nxt();
        nxt();
        done = 1'b1;
    end

endmodule : tb_tick_divider_bank

`default_nettype wire
